// File: rtl/alu_op_sequencer.sv
// Command sequencer for an external 74181-style ALU slice: decodes opcodes, runs one or two
// slice passes (low then high for wide ops), keeps a sticky carry and returns a valid/ready result.
module alu_op_sequencer #(
   parameter int WIDTH         = 8,
   parameter int SETTLE_CYCLES = 1
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [3:0]           cmd_op,
   input  logic                 cmd_wide,
   input  logic [2*WIDTH-1:0]   cmd_a,
   input  logic [2*WIDTH-1:0]   cmd_b,
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic [2*WIDTH-1:0]   res_data,
   output logic                 res_carry,
   output logic                 res_zero,
   output logic                 res_err,
   output logic                 ALU_Mode,
   output logic [3:0]           ALU_Selector,
   output logic [WIDTH-1:0]     ALU_A,
   output logic [WIDTH-1:0]     ALU_B,
   output logic                 ALU_CarryIn,
   input  logic [WIDTH-1:0]     ALU_F,
   input  logic                 ALU_CarryOut,
   input  logic                 ALU_ZeroFlag
);

   localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, EXEC_LO, EXEC_HI, RESP} state_t;

   typedef struct packed {
      logic       legal;
      logic       arith;
      logic       use_cf;
      logic       cn;
      logic [3:0] sel;
   } dec_t;

   // Carry-in polarity is the ALU's: cn=1 means no carry into the low slice.
   function automatic dec_t decode_op(input logic [3:0] op);
      dec_t d;
      d = '{legal: 1'b1, arith: 1'b0, use_cf: 1'b0, cn: 1'b1, sel: 4'h0};
      case (op)
         4'h0: d.sel = 4'h0;
         4'h1: d.sel = 4'h4;
         4'h2: d.sel = 4'h1;
         4'h3: d.sel = 4'h9;
         4'h4: d.sel = 4'hf;
         4'h5: d.sel = 4'hc;
         4'h6: begin d.arith = 1'b1; d.sel = 4'h6; end
         4'h7: begin d.arith = 1'b1; d.sel = 4'h6; d.use_cf = 1'b1; end
         4'h8: begin d.arith = 1'b1; d.sel = 4'h9; d.cn = 1'b0; end
         4'h9: begin d.arith = 1'b1; d.sel = 4'h9; d.use_cf = 1'b1; end
         4'ha: begin d.arith = 1'b1; d.sel = 4'hf; d.cn = 1'b0; end
         4'hb: begin d.arith = 1'b1; d.sel = 4'h0; end
         default: d.legal = 1'b0;
      endcase
      return d;
   endfunction

   state_t             state_r;
   dec_t               dec_s;
   logic [CNT_W-1:0]   settle_cnt_r;
   logic               settle_last_s;
   logic               cf_r;
   logic               arith_r;
   logic               wide_r;
   logic [WIDTH-1:0]   a_hi_r;
   logic [WIDTH-1:0]   b_hi_r;
   logic [WIDTH-1:0]   lo_f_r;
   logic               lo_zero_r;

   assign dec_s         = decode_op(cmd_op);
   assign settle_last_s = (settle_cnt_r == CNT_LAST);
   assign cmd_ready     = (state_r == IDLE);

   // Sequencer FSM with registered ALU drive and result outputs.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_r      <= IDLE;
         settle_cnt_r <= '0;
         cf_r         <= 1'b0;
         arith_r      <= 1'b0;
         wide_r       <= 1'b0;
         a_hi_r       <= '0;
         b_hi_r       <= '0;
         lo_f_r       <= '0;
         lo_zero_r    <= 1'b0;
         res_valid    <= 1'b0;
         res_data     <= '0;
         res_carry    <= 1'b0;
         res_zero     <= 1'b0;
         res_err      <= 1'b0;
         ALU_Mode     <= 1'b1;
         ALU_Selector <= 4'h0;
         ALU_A        <= '0;
         ALU_B        <= '0;
         ALU_CarryIn  <= 1'b1;
      end else begin
         case (state_r)
            IDLE: begin
               if (cmd_valid) begin
                  arith_r <= dec_s.arith;
                  wide_r  <= cmd_wide;
                  a_hi_r  <= cmd_a[2*WIDTH-1:WIDTH];
                  b_hi_r  <= cmd_b[2*WIDTH-1:WIDTH];
                  if (dec_s.legal) begin
                     state_r      <= EXEC_LO;
                     settle_cnt_r <= '0;
                     res_err      <= 1'b0;
                     ALU_Mode     <= ~dec_s.arith;
                     ALU_Selector <= dec_s.sel;
                     ALU_A        <= cmd_a[WIDTH-1:0];
                     ALU_B        <= cmd_b[WIDTH-1:0];
                     ALU_CarryIn  <= dec_s.use_cf ? ~cf_r : dec_s.cn;
                  end else begin
                     state_r   <= RESP;
                     res_valid <= 1'b1;
                     res_err   <= 1'b1;
                     res_data  <= '0;
                     res_carry <= 1'b0;
                     res_zero  <= 1'b0;
                  end
               end
            end
            EXEC_LO: begin
               if (settle_last_s) begin
                  settle_cnt_r <= '0;
                  if (wide_r) begin
                     state_r     <= EXEC_HI;
                     lo_f_r      <= ALU_F;
                     lo_zero_r   <= ~ALU_ZeroFlag;
                     ALU_A       <= a_hi_r;
                     ALU_B       <= b_hi_r;
                     // Ripple the active-low carry straight into the high slice.
                     ALU_CarryIn <= arith_r ? ALU_CarryOut : 1'b1;
                  end else begin
                     state_r   <= RESP;
                     res_valid <= 1'b1;
                     res_data  <= {{WIDTH{1'b0}}, ALU_F};
                     res_zero  <= ~ALU_ZeroFlag;
                     res_carry <= arith_r & ~ALU_CarryOut;
                     if (arith_r) begin
                        cf_r <= ~ALU_CarryOut;
                     end
                  end
               end else begin
                  settle_cnt_r <= settle_cnt_r + CNT_W'(1);
               end
            end
            EXEC_HI: begin
               if (settle_last_s) begin
                  settle_cnt_r <= '0;
                  state_r      <= RESP;
                  res_valid    <= 1'b1;
                  res_data     <= {ALU_F, lo_f_r};
                  res_zero     <= lo_zero_r & ~ALU_ZeroFlag;
                  res_carry    <= arith_r & ~ALU_CarryOut;
                  if (arith_r) begin
                     cf_r <= ~ALU_CarryOut;
                  end
               end else begin
                  settle_cnt_r <= settle_cnt_r + CNT_W'(1);
               end
            end
            RESP: begin
               if (res_ready) begin
                  state_r   <= IDLE;
                  res_valid <= 1'b0;
               end
            end
            default: begin
               state_r   <= IDLE;
               res_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed plus short random bench for alu_op_sequencer driving a behavioural ALU slice;
// expected results come from a 16-bit reference calculation queued at each accept.
module tb_alu_op_sequencer;

   localparam int SETTLE = 1;

   logic        clk;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [3:0]  cmd_op;
   logic        cmd_wide;
   logic [15:0] cmd_a;
   logic [15:0] cmd_b;
   logic        res_valid;
   logic        res_ready;
   logic [15:0] res_data;
   logic        res_carry;
   logic        res_zero;
   logic        res_err;
   logic        alu_mode;
   logic [3:0]  alu_sel;
   logic [7:0]  alu_a;
   logic [7:0]  alu_b;
   logic        alu_cn;
   logic [7:0]  alu_f;
   logic        alu_co;
   logic        alu_zf;

   alu_op_sequencer #(.WIDTH(8), .SETTLE_CYCLES(SETTLE)) dut (
      .CLK(clk), .RST(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_wide(cmd_wide),
      .cmd_a(cmd_a), .cmd_b(cmd_b),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .res_carry(res_carry), .res_zero(res_zero), .res_err(res_err),
      .ALU_Mode(alu_mode), .ALU_Selector(alu_sel), .ALU_A(alu_a), .ALU_B(alu_b),
      .ALU_CarryIn(alu_cn), .ALU_F(alu_f), .ALU_CarryOut(alu_co), .ALU_ZeroFlag(alu_zf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural ALU slice: active-low carries, active-low zero flag.
   logic [8:0] alu_sum;
   logic       alu_cin;
   always_comb begin
      alu_f   = 8'h00;
      alu_sum = 9'h000;
      alu_cin = ~alu_cn;
      alu_co  = 1'b1;
      if (alu_mode) begin
         case (alu_sel)
            4'h0: alu_f = alu_a;
            4'h4: alu_f = alu_a & alu_b;
            4'h1: alu_f = alu_a | alu_b;
            4'h9: alu_f = alu_a ^ alu_b;
            4'hf: alu_f = ~alu_a;
            4'hc: alu_f = 8'h00;
            default: alu_f = 8'h00;
         endcase
      end else begin
         case (alu_sel)
            4'h6: alu_sum = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_cin};
            4'h9: alu_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + {8'h00, alu_cin};
            4'hf: alu_sum = {1'b0, alu_a} + {8'h00, alu_cin};
            4'h0: alu_sum = {1'b0, alu_a} + 9'h0ff + {8'h00, alu_cin};
            default: alu_sum = 9'h000;
         endcase
         alu_f  = alu_sum[7:0];
         alu_co = ~alu_sum[8];
      end
      alu_zf = (alu_f != 8'h00);
   end

   typedef struct packed {
      logic [15:0] data;
      logic        carry;
      logic        zero;
      logic        err;
      logic        arith;
      logic [7:0]  lat;
   } exp_t;

   exp_t sb[$];
   logic cf_model = 1'b0;
   int   accept_cyc = 0;
   int   n_cmp = 0;
   int   n_fail = 0;

   function automatic exp_t ref_op(input logic [3:0] op, input logic wide,
                                   input logic [15:0] a, input logic [15:0] b, input logic cf);
      exp_t        e;
      logic [16:0] r;
      logic [16:0] am;
      logic [16:0] bm;
      logic [16:0] mask;
      mask = wide ? 17'h0ffff : 17'h000ff;
      am   = {1'b0, a} & mask;
      bm   = {1'b0, b} & mask;
      r    = 17'h0;
      e    = '0;
      e.arith = (op >= 4'h6) && (op <= 4'hb);
      case (op)
         4'h0: r = am;
         4'h1: r = am & bm;
         4'h2: r = am | bm;
         4'h3: r = am ^ bm;
         4'h4: r = ~am & mask;
         4'h5: r = 17'h0;
         4'h6: r = am + bm;
         4'h7: r = am + bm + {16'h0, cf};
         4'h8: r = am + (~bm & mask) + 17'h1;
         4'h9: r = am + (~bm & mask) + {16'h0, cf};
         4'ha: r = am + 17'h1;
         4'hb: r = am + mask;
         default: e.err = 1'b1;
      endcase
      if (e.err) begin
         e.lat = 8'd0;
      end else begin
         e.data  = r[15:0] & mask[15:0];
         e.zero  = (e.data == 16'h0000);
         e.carry = e.arith & (wide ? r[16] : r[8]);
         e.lat   = wide ? 8'(2 * SETTLE) : 8'(SETTLE);
      end
      return e;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [3:0] op, input logic wide, input logic [15:0] a, input logic [15:0] b);
      exp_t e;
      int   n;
      @(negedge clk);
      n = 0;
      while (!cmd_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("cmd_ready_before_send", {31'h0, cmd_ready}, 32'h1);
      cmd_op    = op;
      cmd_wide  = wide;
      cmd_a     = a;
      cmd_b     = b;
      cmd_valid = 1'b1;
      e = ref_op(op, wide, a, b, cf_model);
      sb.push_back(e);
      if (e.arith && !e.err) cf_model = e.carry;
      @(posedge clk);
      #1;
      cmd_valid  = 1'b0;
      accept_cyc = cyc;
   endtask

   task automatic collect(input int hold);
      exp_t e;
      int   n;
      @(negedge clk);
      n = 0;
      while (!res_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("res_valid_timeout", {31'h0, res_valid}, 32'h1);
      e = sb.pop_front();
      check("latency", cyc - accept_cyc, {24'h0, e.lat});
      check("res_data", {16'h0, res_data}, {16'h0, e.data});
      check("res_carry", {31'h0, res_carry}, {31'h0, e.carry});
      check("res_zero", {31'h0, res_zero}, {31'h0, e.zero});
      check("res_err", {31'h0, res_err}, {31'h0, e.err});
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("stall_valid", {31'h0, res_valid}, 32'h1);
         check("stall_data", {16'h0, res_data}, {16'h0, e.data});
         check("stall_cmd_ready", {31'h0, cmd_ready}, 32'h0);
      end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      check("post_hs_valid", {31'h0, res_valid}, 32'h0);
      check("post_hs_cmd_ready", {31'h0, cmd_ready}, 32'h1);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_ctl"}, {25'h0, cmd_ready, res_valid, res_carry, res_zero, res_err, alu_mode, alu_cn},
            {25'h0, 7'b1000011});
      check({tag, "_data"}, {16'h0, res_data}, 32'h0);
      check({tag, "_alu"}, {12'h0, alu_sel, alu_a, alu_b}, 32'h0);
   endtask

   logic [20:0] alu_snap;

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; cmd_op = 4'h0; cmd_wide = 1'b0;
      cmd_a = 16'h0; cmd_b = 16'h0; res_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check_reset_values("reset");

      // Narrow ADD with carry out; check ALU drive after accept.
      send(4'h6, 1'b0, 16'h00f1, 16'h000f);
      @(negedge clk);
      check("add_alu_ctl", {27'h0, alu_mode, alu_sel, alu_cn}, {27'h0, 1'b0, 4'h6, 1'b1});
      collect(0);

      send(4'h8, 1'b0, 16'h0001, 16'h0003);
      collect(0);
      send(4'h9, 1'b0, 16'h0010, 16'h0001);
      @(negedge clk);
      check("sbb_cn", {31'h0, alu_cn}, 32'h1);
      collect(0);

      // Wide ADD: low then high operands, rippled carry-in.
      send(4'h6, 1'b1, 16'h00ff, 16'h0001);
      @(negedge clk);
      check("wide_lo_a", {24'h0, alu_a}, 32'h000000ff);
      @(negedge clk);
      check("wide_hi_a", {24'h0, alu_a}, 32'h0);
      check("wide_hi_cn", {31'h0, alu_cn}, 32'h0);
      collect(0);

      send(4'ha, 1'b0, 16'habfe, 16'h0000);
      collect(0);
      send(4'h6, 1'b0, 16'h00ff, 16'h0001);
      collect(0);
      send(4'h1, 1'b0, 16'h0021, 16'h000f);
      collect(0);
      send(4'h7, 1'b0, 16'h0001, 16'h0001);
      collect(0);

      send(4'h3, 1'b0, 16'h005a, 16'h00a5);
      collect(5);

      // Illegal opcode preserves cf and the ALU drive.
      send(4'h8, 1'b0, 16'h0005, 16'h0003);
      collect(0);
      alu_snap = {alu_mode, alu_sel, alu_a, alu_b, alu_cn};
      send(4'hd, 1'b0, 16'h1234, 16'h5678);
      collect(0);
      check("illegal_alu_hold", {11'h0, alu_mode, alu_sel, alu_a, alu_b, alu_cn}, {11'h0, alu_snap});
      send(4'h9, 1'b0, 16'h0005, 16'h0002);
      collect(0);

      send(4'h8, 1'b1, 16'h0100, 16'h0001);
      collect(0);
      send(4'h4, 1'b1, 16'h1234, 16'h0000);
      collect(0);
      send(4'hb, 1'b0, 16'h0000, 16'h0000);
      collect(0);
      send(4'h5, 1'b1, 16'hffff, 16'hffff);
      collect(0);
      send(4'h7, 1'b1, 16'hffff, 16'h0000);
      collect(0);

      // Reset in EXEC_HI discards the result and clears cf.
      send(4'h6, 1'b0, 16'h00ff, 16'h0001);
      collect(0);
      send(4'h1, 1'b1, 16'h1234, 16'hffff);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_reset_values("mid_reset");
      void'(sb.pop_back());
      cf_model = 1'b0;
      send(4'h7, 1'b0, 16'h0001, 16'h0001);
      collect(0);

      for (int i = 0; i < 24; i++) begin
         send(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
         collect(0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
